// File: rtl/video_sync_if.sv
// Video stream from the colour-bar generator: sync pair plus 3-bit {r,g,b} pixel.
// The generator drives the master side and the sync monitor samples the slave side.
interface video_sync_if;
   logic       hsync;
   logic       vsync;
   logic [2:0] rgb;

   modport master (output hsync, output vsync, output rgb);
   modport slave  (input  hsync, input  vsync, input  rgb);
endinterface

// File: rtl/video_sync_monitor.sv
// Measures line period, lines per frame and lit pixels per line of the generator output,
// and declares lock after LOCK_FRAMES consecutive frames with the expected timing.
module video_sync_monitor #(
   parameter int SYNC_ACTIVE_LOW = 1,
   parameter int EXPECT_H_TOTAL  = 381,
   parameter int EXPECT_V_TOTAL  = 262,
   parameter int LOCK_FRAMES     = 4
) (
   input  logic          clk,
   input  logic          reset,
   video_sync_if.slave   vid,
   output logic          locked,
   output logic [9:0]    line_len,
   output logic [9:0]    frame_lines,
   output logic [9:0]    active_len,
   output logic          frame_strobe,
   output logic          err_pulse
);

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_TRACK  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam logic       SYNC_POL = (SYNC_ACTIVE_LOW != 0);
   localparam logic [9:0] H_TOT    = 10'(EXPECT_H_TOTAL);
   localparam logic [9:0] V_TOT    = 10'(EXPECT_V_TOTAL);
   localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);

   function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic en);
      logic [10:0] s;
      s = {1'b0, v} + {10'd0, en};
      if (s[10]) begin
         return 10'd1023;
      end else begin
         return s[9:0];
      end
   endfunction

   logic       hs_s, vs_s, hs_q_r, vs_q_r;
   logic       hstart_s, vstart_s, lit_s;
   logic [9:0] h_cnt_r, a_cnt_r, v_cnt_r;
   logic       line_err_r;
   logic [3:0] good_cnt_r;
   logic [1:0] state_r;

   logic [9:0] line_meas_s, act_meas_s, frame_cnt_s;
   logic       h_sat_s, line_bad_s, err_now_s, frame_good_s;
   logic [1:0] state_nx_s;
   logic [3:0] good_nx_s;
   logic       err_nx_s;

   assign hs_s     = vid.hsync ^ SYNC_POL;
   assign vs_s     = vid.vsync ^ SYNC_POL;
   assign hstart_s = hs_s & ~hs_q_r;
   assign vstart_s = vs_s & ~vs_q_r;
   assign lit_s    = |vid.rgb;

   // Measurements as they would be latched this cycle; the frame verdict folds in a same-cycle hstart.
   always_comb begin
      line_meas_s  = sat_inc(h_cnt_r, 1'b1);
      act_meas_s   = sat_inc(a_cnt_r, lit_s);
      frame_cnt_s  = sat_inc(v_cnt_r, hstart_s);
      h_sat_s      = (h_cnt_r == 10'd1023);
      line_bad_s   = hstart_s & (line_meas_s != H_TOT);
      err_now_s    = line_err_r | line_bad_s | h_sat_s;
      frame_good_s = (frame_cnt_s == V_TOT) & ~err_now_s;
   end

   // Acquisition state machine; a saturated line counter means the sync has died.
   always_comb begin
      state_nx_s = state_r;
      good_nx_s  = good_cnt_r;
      err_nx_s   = 1'b0;
      case (state_r)
         ST_SEARCH: begin
            if (vstart_s) begin
               state_nx_s = ST_TRACK;
               good_nx_s  = 4'd0;
            end else begin
               state_nx_s = ST_SEARCH;
            end
         end
         ST_TRACK: begin
            if (h_sat_s) begin
               state_nx_s = ST_SEARCH;
               good_nx_s  = 4'd0;
            end else if (vstart_s && frame_good_s) begin
               good_nx_s = good_cnt_r + 4'd1;
               if (good_cnt_r + 4'd1 == LOCK_N) begin
                  state_nx_s = ST_LOCKED;
               end else begin
                  state_nx_s = ST_TRACK;
               end
            end else if (vstart_s) begin
               good_nx_s = 4'd0;
            end else begin
               state_nx_s = ST_TRACK;
            end
         end
         ST_LOCKED: begin
            if (h_sat_s) begin
               state_nx_s = ST_SEARCH;
               good_nx_s  = 4'd0;
            end else if (vstart_s && !frame_good_s) begin
               state_nx_s = ST_TRACK;
               good_nx_s  = 4'd0;
               err_nx_s   = 1'b1;
            end else begin
               state_nx_s = ST_LOCKED;
            end
         end
         default: begin
            state_nx_s = ST_SEARCH;
            good_nx_s  = 4'd0;
         end
      endcase
   end

   // Counters, latched measurements, sticky line error and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q_r       <= 1'b0;
         vs_q_r       <= 1'b0;
         h_cnt_r      <= 10'd0;
         a_cnt_r      <= 10'd0;
         v_cnt_r      <= 10'd0;
         line_err_r   <= 1'b0;
         good_cnt_r   <= 4'd0;
         state_r      <= ST_SEARCH;
         locked       <= 1'b0;
         line_len     <= 10'd0;
         frame_lines  <= 10'd0;
         active_len   <= 10'd0;
         frame_strobe <= 1'b0;
         err_pulse    <= 1'b0;
      end else begin
         hs_q_r <= hs_s;
         vs_q_r <= vs_s;
         if (hstart_s) begin
            line_len   <= line_meas_s;
            active_len <= act_meas_s;
            h_cnt_r    <= 10'd0;
            a_cnt_r    <= 10'd0;
         end else begin
            h_cnt_r <= line_meas_s;
            a_cnt_r <= act_meas_s;
         end
         // A line that ends on the vstart cycle belongs to the frame that is ending.
         if (vstart_s) begin
            frame_lines <= frame_cnt_s;
            v_cnt_r     <= 10'd0;
            line_err_r  <= 1'b0;
         end else begin
            v_cnt_r <= frame_cnt_s;
            if (line_bad_s || h_sat_s) begin
               line_err_r <= 1'b1;
            end else begin
               line_err_r <= line_err_r;
            end
         end
         frame_strobe <= vstart_s;
         err_pulse    <= err_nx_s;
         state_r      <= state_nx_s;
         good_cnt_r   <= good_nx_s;
         locked       <= (state_nx_s == ST_LOCKED);
      end
   end

endmodule

// File: tb/tb_video_sync_monitor.sv
// Drives a scaled colour-bar stream (48 clocks x 20 lines) into a negative-sync and a positive-sync
// monitor; a frame table supplies hand-computed results that a monitor process checks per vstart.
module tb_video_sync_monitor;
   localparam int HT      = 48;
   localparam int VT      = 20;
   localparam int HS_POS  = 36;
   localparam int LIT_END = 28;
   localparam int NF      = 33;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   video_sync_if vn ();
   video_sync_if vp ();

   logic [1:0] locked, frame_strobe, err_pulse;
   logic [9:0] line_len [2];
   logic [9:0] frame_lines [2];
   logic [9:0] active_len [2];

   video_sync_monitor #(.SYNC_ACTIVE_LOW(1), .EXPECT_H_TOTAL(HT), .EXPECT_V_TOTAL(VT), .LOCK_FRAMES(4)) dut_n (
      .clk(clk), .reset(reset), .vid(vn), .locked(locked[0]), .line_len(line_len[0]),
      .frame_lines(frame_lines[0]), .active_len(active_len[0]), .frame_strobe(frame_strobe[0]),
      .err_pulse(err_pulse[0]));

   video_sync_monitor #(.SYNC_ACTIVE_LOW(0), .EXPECT_H_TOTAL(HT), .EXPECT_V_TOTAL(VT), .LOCK_FRAMES(4)) dut_p (
      .clk(clk), .reset(reset), .vid(vp), .locked(locked[1]), .line_len(line_len[1]),
      .frame_lines(frame_lines[1]), .active_len(active_len[1]), .frame_strobe(frame_strobe[1]),
      .err_pulse(err_pulse[1]));

   typedef struct {
      int do_lines;
      int lines;
      int act;
      int err;
      int lock;
      int idx;
   } fexp_t;
   typedef struct {
      int val;
      int cyc;
   } lexp_t;

   fexp_t fq[$];
   lexp_t lq[$];
   int    fidx [2];
   int    lidx [2];
   logic  prev_lock [2];
   int    cyc = 0;
   int    rst_chk_cyc = 3;
   int    errors = 0;
   int    checks = 0;

   // Frame table: stream shape of frame i, and the expected outputs at the vstart that starts it.
   int nl [NF], sh [NF], vsh [NF], hoff [NF], blk [NF], rstp [NF];
   int exl [NF], exa [NF], exe [NF], exk [NF], chkl [NF], ev [NF];

   task automatic chk(input string name, input int d, input int tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d item %0d: got %0d, expected %0d (cycle %0d)", name, d, tag, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: compares each DUT whenever it presents a strobe, a lock edge or a reset.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (cyc == rst_chk_cyc) begin
            chk("rst_locked", d, cyc, int'(locked[d]), 0);
            chk("rst_line_len", d, cyc, int'(line_len[d]), 0);
            chk("rst_frame_lines", d, cyc, int'(frame_lines[d]), 0);
            chk("rst_active_len", d, cyc, int'(active_len[d]), 0);
            chk("rst_strobe", d, cyc, int'(frame_strobe[d]), 0);
            chk("rst_err", d, cyc, int'(err_pulse[d]), 0);
         end
         if (frame_strobe[d]) begin
            if (fidx[d] < fq.size()) begin
               if (fq[fidx[d]].do_lines != 0)
                  chk("frame_lines", d, fq[fidx[d]].idx, int'(frame_lines[d]), fq[fidx[d]].lines);
               chk("line_len", d, fq[fidx[d]].idx, int'(line_len[d]), HT);
               chk("active_len", d, fq[fidx[d]].idx, int'(active_len[d]), fq[fidx[d]].act);
               chk("err_pulse", d, fq[fidx[d]].idx, int'(err_pulse[d]), fq[fidx[d]].err);
               chk("locked_at_strobe", d, fq[fidx[d]].idx, int'(locked[d]), fq[fidx[d]].lock);
               fidx[d]++;
            end else begin
               chk("strobe_count", d, cyc, fidx[d] + 1, fq.size());
            end
         end else begin
            chk("err_idle", d, cyc, int'(err_pulse[d]), 0);
         end
         if (locked[d] != prev_lock[d]) begin
            if (lidx[d] < lq.size()) begin
               chk("lock_value", d, lidx[d], int'(locked[d]), lq[lidx[d]].val);
               chk("lock_cycle", d, lidx[d], cyc, lq[lidx[d]].cyc);
               lidx[d]++;
            end else begin
               chk("lock_edge_count", d, cyc, lidx[d] + 1, lq.size());
            end
         end
         prev_lock[d] = locked[d];
      end
   end

   task automatic drive(input bit hs, input bit vs, input logic [2:0] px);
      vn.hsync = ~hs;
      vn.vsync = ~vs;
      vp.hsync = hs;
      vp.vsync = vs;
      vn.rgb   = px;
      vp.rgb   = px;
   endtask

   initial begin
      int    hlen, last_hs;
      bit    hs_act, vs_act;
      fexp_t fe;
      lexp_t le;
      logic [2:0] px;

      for (int i = 0; i < 2; i++) begin
         fidx[i] = 0;
         lidx[i] = 0;
         prev_lock[i] = 1'b0;
      end
      for (int i = 0; i < NF; i++) begin
         nl[i] = VT; sh[i] = -1; vsh[i] = 0; hoff[i] = 0; blk[i] = 0; rstp[i] = 0;
         chkl[i] = 1; exl[i] = VT; exa[i] = LIT_END; exe[i] = 0; exk[i] = 0; ev[i] = 0;
      end
      chkl[1] = 0;
      exk[5] = 1;  ev[5] = 1;
      sh[6] = 5;   exk[6] = 1;
      blk[7] = 1;  exe[7] = 1;  ev[7] = 2;
      exa[8] = 0;
      nl[11] = 19; exk[11] = 1; ev[11] = 1;
      exl[12] = 19; exe[12] = 1; ev[12] = 2;
      nl[16] = 30; hoff[16] = 1; exk[16] = 1; ev[16] = 1;
      exl[17] = 0;
      exk[22] = 1; ev[22] = 1;
      for (int i = 23; i < NF; i++) vsh[i] = HS_POS;
      exl[23] = 21; exe[23] = 1; ev[23] = 2;
      rstp[27] = 1; exk[27] = 1; ev[27] = 1;
      chkl[28] = 0;
      nl[32] = 3; exk[32] = 1; ev[32] = 1;

      last_hs = 0;
      reset = 1'b1;
      drive(1'b0, 1'b0, 3'd0);
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;

      for (int f = 0; f < NF; f++) begin
         for (int v = (f == 0) ? 10 : 0; v < nl[f]; v++) begin
            hlen = (v == sh[f]) ? HT - 1 : HT;
            for (int h = 0; h < hlen; h++) begin
               @(posedge clk);
               #1;
               reset  = 1'b0;
               hs_act = (hoff[f] == 0) && (h >= HS_POS) && (h < HS_POS + 4);
               vs_act = (v < 3) && !(v == 0 && h < vsh[f]);
               if (hs_act && h == HS_POS) last_hs = cyc;
               if (f > 0 && v == 0 && h == vsh[f]) begin
                  fe.do_lines = chkl[f]; fe.lines = exl[f]; fe.act = exa[f];
                  fe.err = exe[f]; fe.lock = exk[f]; fe.idx = f;
                  fq.push_back(fe);
                  if (ev[f] != 0) begin
                     le.val = (ev[f] == 1) ? 1 : 0;
                     le.cyc = cyc + 1;
                     lq.push_back(le);
                  end
               end
               if (hoff[f] != 0 && v == 0 && h == 1) begin
                  le.val = 0;
                  le.cyc = last_hs + 1025;
                  lq.push_back(le);
               end
               if (rstp[f] != 0 && v == 5 && h == 10) begin
                  reset = 1'b1;
                  rst_chk_cyc = cyc + 1;
                  le.val = 0;
                  le.cyc = cyc + 1;
                  lq.push_back(le);
               end
               px = (blk[f] == 0 && h < LIT_END) ? 3'(7 - h / 4) : 3'd0;
               drive(hs_act, vs_act, px);
            end
         end
      end

      @(posedge clk);
      #1 drive(1'b0, 1'b0, 3'd0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("strobes_seen", d, 0, fidx[d], fq.size());
         chk("lock_edges_seen", d, 0, lidx[d], lq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
